// File: rtl/i2c_req_arbiter_pkg.sv
// Shared definitions for the I2C request arbiter: FSM states, completion codes,
// and I2C field widths.
package i2c_req_arbiter_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 8;
   localparam int ERR_W  = 2;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LAUNCH     = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_RESP       = 3'd4
   } state_e;

   localparam logic [ERR_W-1:0] ERR_OK      = 2'b00;
   localparam logic [ERR_W-1:0] ERR_NACK    = 2'b01;
   localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/i2c_req_arbiter_rr_picker.sv
// Combinational round-robin picker: searches req starting at rr_ptr and
// returns the first set requester as a one-hot vector plus its index.
module i2c_req_arbiter_rr_picker #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PTR_W-1:0]   rr_ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0]   gnt_idx_o
);

   int               slot;
   logic             found;
   logic [PTR_W-1:0] slot_idx;

   // Walk the requesters in rotated order; the first hit wins.
   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      slot      = 0;
      slot_idx  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         slot = int'(rr_ptr_i) + i;
         if (slot >= NUM_REQ) begin
            slot = slot - NUM_REQ;
         end
         slot_idx = PTR_W'(slot);
         if (!found && req_i[slot_idx]) begin
            found           = 1'b1;
            gnt_o[slot_idx] = 1'b1;
            gnt_idx_o       = slot_idx;
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Arbitrates several requesters onto a single I2C master. One transaction at a
// time: pick a winner round-robin, latch its fields, strobe the master, wait
// for it to go busy and return idle (or time out), then report completion.
//
// state         | meaning
// --------------+------------------------------------------------------------
// ST_IDLE       | no transaction; arbitrate when master is ready
// ST_LAUNCH     | winner latched, grant held; strobe m_enable next
// ST_WAIT_START | m_enable issued; waiting for master to drop m_ready
// ST_WAIT_DONE  | master busy; waiting for m_ready to return
// ST_RESP       | done pulse with rdata/err; release grant, advance pointer
module i2c_req_arbiter
   import i2c_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0]        req_rw,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        done,
   output logic [DATA_W-1:0]         rdata,
   output logic [ERR_W-1:0]          err,
   output logic                      m_enable,
   output logic [ADDR_W-1:0]         m_addr,
   output logic                      m_rw,
   output logic [DATA_W-1:0]         m_wdata,
   input  logic                      m_ready,
   input  logic [DATA_W-1:0]         m_rdata,
   input  logic                      m_nack,
   output logic                      busy
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int TMO_W = $clog2(TIMEOUT_CYC);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   state_e                state_q;
   logic [PTR_W-1:0]      rr_ptr_q;
   logic [PTR_W-1:0]      win_q;
   logic [TMO_W-1:0]      tmo_q;
   logic [NUM_REQ-1:0]    grant_q;
   logic [NUM_REQ-1:0]    done_q;
   logic [DATA_W-1:0]     rdata_q;
   logic [ERR_W-1:0]      err_q;
   logic                  m_enable_q;
   logic [ADDR_W-1:0]     m_addr_q;
   logic                  m_rw_q;
   logic [DATA_W-1:0]     m_wdata_q;
   logic                  busy_q;

   logic [NUM_REQ-1:0]    pick_gnt_d;
   logic [PTR_W-1:0]      pick_idx_d;
   logic                  tmo_last;

   logic [ADDR_W-1:0]     addr_arr  [NUM_REQ];
   logic [DATA_W-1:0]     wdata_arr [NUM_REQ];

   // Unpack the flat per-requester buses so the winner can be selected by index.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
   end

   i2c_req_arbiter_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_picker (
      .req_i     (req),
      .rr_ptr_i  (rr_ptr_q),
      .gnt_o     (pick_gnt_d),
      .gnt_idx_o (pick_idx_d)
   );

   assign tmo_last = (tmo_q == TMO_LAST);

   // Transaction sequencer; every output is registered here.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         rr_ptr_q   <= '0;
         win_q      <= '0;
         tmo_q      <= '0;
         grant_q    <= '0;
         done_q     <= '0;
         rdata_q    <= '0;
         err_q      <= ERR_OK;
         m_enable_q <= 1'b0;
         m_addr_q   <= '0;
         m_rw_q     <= 1'b0;
         m_wdata_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         done_q     <= '0;
         m_enable_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (m_ready && (|req)) begin
                  state_q   <= ST_LAUNCH;
                  grant_q   <= pick_gnt_d;
                  win_q     <= pick_idx_d;
                  m_addr_q  <= addr_arr[pick_idx_d];
                  m_rw_q    <= req_rw[pick_idx_d];
                  m_wdata_q <= wdata_arr[pick_idx_d];
                  busy_q    <= 1'b1;
               end
            end
            ST_LAUNCH: begin
               m_enable_q <= 1'b1;
               tmo_q      <= '0;
               state_q    <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               // A master that never accepts still has to be released by the timer.
               if (tmo_last) begin
                  state_q <= ST_RESP;
                  done_q  <= grant_q;
                  err_q   <= ERR_TIMEOUT;
                  rdata_q <= '0;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
                  if (!m_ready) begin
                     state_q <= ST_WAIT_DONE;
                  end
               end
            end
            ST_WAIT_DONE: begin
               // m_ready is checked first so a completion on the last budget cycle counts.
               if (m_ready) begin
                  state_q <= ST_RESP;
                  done_q  <= grant_q;
                  rdata_q <= m_rdata;
                  err_q   <= m_nack ? ERR_NACK : ERR_OK;
               end else if (tmo_last) begin
                  state_q <= ST_RESP;
                  done_q  <= grant_q;
                  err_q   <= ERR_TIMEOUT;
                  rdata_q <= '0;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            ST_RESP: begin
               grant_q  <= '0;
               busy_q   <= 1'b0;
               rr_ptr_q <= (win_q == PTR_LAST) ? '0 : win_q + 1'b1;
               state_q  <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant    = grant_q;
   assign done     = done_q;
   assign rdata    = rdata_q;
   assign err      = err_q;
   assign m_enable = m_enable_q;
   assign m_addr   = m_addr_q;
   assign m_rw     = m_rw_q;
   assign m_wdata  = m_wdata_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: stimulus pushes expected completions,
// monitors pop and compare on every done pulse. A second instance with a
// short timeout budget covers the timeout boundaries.
module tb_i2c_req_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] done;
      logic [6:0] addr;
      logic       rw;
      logic [7:0] wdata;
      logic       chk_rd;
      logic [7:0] rdata;
      logic [1:0] err;
   } exp_t;

   exp_t q[$];
   exp_t tq[$];
   exp_t cur;
   exp_t tcur;

   // ---------------- main instance (4 requesters, long budget) ----------------
   logic [3:0]  req = '0;
   logic [27:0] req_addr = '0;
   logic [3:0]  req_rw = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  grant, done;
   logic [7:0]  rdata, m_wdata, m_rdata;
   logic [1:0]  err;
   logic        m_enable, m_rw, m_nack, busy, m_ready;
   logic [6:0]  m_addr;
   logic        m_rdy_mdl = 1'b1;
   logic        m_block = 1'b0;
   assign m_ready = m_rdy_mdl & ~m_block;

   i2c_req_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(256)) u_dut (
      .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
      .req_wdata(req_wdata), .grant(grant), .done(done), .rdata(rdata), .err(err),
      .m_enable(m_enable), .m_addr(m_addr), .m_rw(m_rw), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rdata(m_rdata), .m_nack(m_nack), .busy(busy));

   int         m_lat = 5;
   logic [7:0] m_rd_cfg = 8'h00;
   logic       m_nack_cfg = 1'b0;
   bit         m_act = 0;
   int         m_cnt = 0;
   int         en_cnt = 0;

   initial begin
      m_rdata = 8'h00;
      m_nack  = 1'b0;
   end

   // Master model: goes busy after seeing m_enable, returns ready after m_lat cycles.
   always @(posedge clk) begin
      if (!rst) begin
         m_act = 0;
         m_rdy_mdl = 1'b1;
      end else if (!m_act && m_enable) begin
         m_act = 1;
         m_cnt = 0;
         #1 m_rdy_mdl = 1'b0;
      end else if (m_act) begin
         m_cnt++;
         if (m_lat >= 0 && m_cnt == m_lat) begin
            m_act = 0;
            #1;
            m_rdata = m_rd_cfg;
            m_nack = m_nack_cfg;
            m_rdy_mdl = 1'b1;
         end
      end
   end

   always @(negedge clk) if (m_enable) en_cnt++;

   // Monitor: every done pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst && done !== 4'b0000) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=%b required=none", done);
         end else begin
            cur = q.pop_front();
            chk("done", done, cur.done);
            chk("m_addr", m_addr, cur.addr);
            chk("m_rw", m_rw, cur.rw);
            chk("m_wdata", m_wdata, cur.wdata);
            chk("err", err, cur.err);
            if (cur.chk_rd) chk("rdata", rdata, cur.rdata);
         end
      end
   end

   task automatic setreq(input int idx, input logic [6:0] a, input logic rw, input logic [7:0] wd);
      req_addr[idx*7 +: 7]  = a;
      req_rw[idx]           = rw;
      req_wdata[idx*8 +: 8] = wd;
   endtask

   task automatic push(input int idx, input logic [6:0] a, input logic rw, input logic [7:0] wd,
                       input logic crd, input logic [7:0] rd, input logic [1:0] e);
      exp_t x;
      x.done = 4'b0001 << idx;
      x.addr = a; x.rw = rw; x.wdata = wd;
      x.chk_rd = crd; x.rdata = rd; x.err = e;
      q.push_back(x);
   endtask

   // Returns at the negedge of the n-th done cycle so the caller can drop req in time.
   task automatic wait_dones(input int n, input int budget, input string name);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (done !== 4'b0000) got++;
      end
      chk(name, got, n);
   endtask

   // ---------------- timeout instance (2 requesters, budget 16) ----------------
   logic [1:0]  t_req = '0;
   logic [13:0] t_req_addr = '0;
   logic [1:0]  t_req_rw = '0;
   logic [15:0] t_req_wdata = '0;
   logic [1:0]  t_grant, t_done, t_err;
   logic [7:0]  t_rdata, t_m_wdata;
   logic [7:0]  t_m_rdata = 8'h00;
   logic        t_m_nack = 1'b0;
   logic        t_m_enable, t_m_rw, t_busy;
   logic        t_m_ready = 1'b1;
   logic [6:0]  t_m_addr;

   i2c_req_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(16)) u_dut_t (
      .clk(clk), .rst(rst), .req(t_req), .req_addr(t_req_addr), .req_rw(t_req_rw),
      .req_wdata(t_req_wdata), .grant(t_grant), .done(t_done), .rdata(t_rdata), .err(t_err),
      .m_enable(t_m_enable), .m_addr(t_m_addr), .m_rw(t_m_rw), .m_wdata(t_m_wdata),
      .m_ready(t_m_ready), .m_rdata(t_m_rdata), .m_nack(t_m_nack), .busy(t_busy));

   int         t_lat = 5;
   logic [7:0] t_rd_cfg = 8'h00;
   bit         t_abort = 0;
   bit         t_act = 0;
   int         t_cnt = 0;

   // Same master model; t_lat < 0 means it never returns until t_abort.
   always @(posedge clk) begin
      if (!rst) begin
         t_act = 0;
         t_m_ready = 1'b1;
      end else if (!t_act && t_m_enable) begin
         t_act = 1;
         t_cnt = 0;
         #1 t_m_ready = 1'b0;
      end else if (t_act) begin
         t_cnt++;
         if ((t_lat >= 0 && t_cnt == t_lat) || t_abort) begin
            t_act = 0;
            #1;
            t_m_rdata = t_rd_cfg;
            t_m_ready = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst && t_done !== 2'b00) begin
         if (tq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL t_unexpected_done actual=%b required=none", t_done);
         end else begin
            tcur = tq.pop_front();
            chk("t_done", t_done, tcur.done[1:0]);
            chk("t_err", t_err, tcur.err);
            chk("t_rdata", t_rdata, tcur.rdata);
            chk("t_m_addr", t_m_addr, tcur.addr);
         end
      end
   end

   // Cycles from the m_enable cycle to the done cycle are counted and compared.
   task automatic t_run(input int idx, input int lat, input logic [7:0] rd,
                        input logic [1:0] e_err, input logic [7:0] e_rd);
      exp_t x;
      int   cyc;
      x.done = 4'b0001 << idx;
      x.addr = 7'h11 + 7'(idx); x.rw = 1'b1; x.wdata = 8'h00;
      x.chk_rd = 1'b1; x.rdata = e_rd; x.err = e_err;
      tq.push_back(x);
      t_req_addr[idx*7 +: 7] = 7'h11 + 7'(idx);
      t_req_rw[idx] = 1'b1;
      t_lat = lat;
      t_rd_cfg = rd;
      t_abort = 0;
      t_req[idx] = 1'b1;
      cyc = 0;
      while (t_m_enable !== 1'b1 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      chk("t_enable_seen", t_m_enable, 1'b1);
      cyc = 0;
      while (t_done === 2'b00 && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      t_req[idx] = 1'b0;
      chk("t_wait_cycles", cyc, 16);
      t_abort = 1;
      repeat (3) @(negedge clk);
      t_abort = 0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int en0;
   int blk_bad;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_hold", {grant, done, m_enable, busy, err, rdata, m_addr, m_rw, m_wdata}, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_release", {grant, done, m_enable, busy, err, rdata, m_addr, m_rw, m_wdata}, 0);

      // Contention: all four held, expected order 0,1,2,3,0
      m_lat = 5;
      for (int i = 0; i < 4; i++) setreq(i, 7'h10 + 7'(i), 1'b0, 8'h20 + 8'(i));
      push(0, 7'h10, 0, 8'h20, 0, 0, 2'b00);
      push(1, 7'h11, 0, 8'h21, 0, 0, 2'b00);
      push(2, 7'h12, 0, 8'h22, 0, 0, 2'b00);
      push(3, 7'h13, 0, 8'h23, 0, 0, 2'b00);
      push(0, 7'h10, 0, 8'h20, 0, 0, 2'b00);
      req = 4'b1111;
      wait_dones(5, 200, "wd_contention");
      req = 4'b0000;
      @(negedge clk);

      // Single write, 40-cycle master
      m_lat = 40;
      setreq(0, 7'h50, 1'b0, 8'hA5);
      push(0, 7'h50, 0, 8'hA5, 0, 0, 2'b00);
      en0 = en_cnt;
      req[0] = 1'b1;
      @(negedge clk);
      chk("grant_latency", grant, 4'b0001);
      chk("enable_early", m_enable, 1'b0);
      @(negedge clk);
      chk("enable_latency", m_enable, 1'b1);
      @(negedge clk);
      chk("enable_pulse", m_enable, 1'b0);
      wait_dones(1, 80, "wd_write");
      req[0] = 1'b0;
      chk("enable_count", en_cnt - en0, 1);
      @(negedge clk);
      chk("after_done", {done, grant, busy}, 0);

      // Read on requester 2 returns 0x3C; pointer moves to 3
      m_lat = 10;
      m_rd_cfg = 8'h3C;
      setreq(2, 7'h2A, 1'b1, 8'h00);
      push(2, 7'h2A, 1, 8'h00, 1, 8'h3C, 2'b00);
      req[2] = 1'b1;
      wait_dones(1, 40, "wd_read");
      req[2] = 1'b0;
      @(negedge clk);

      // Requesters 3 and 0: pointer 3 grants 3 first, then wraps to 0
      m_rd_cfg = 8'h00;
      setreq(3, 7'h0C, 1'b0, 8'h5A);
      setreq(0, 7'h0D, 1'b0, 8'hC3);
      push(3, 7'h0C, 0, 8'h5A, 0, 0, 2'b00);
      push(0, 7'h0D, 0, 8'hC3, 0, 0, 2'b00);
      req = 4'b1001;
      wait_dones(1, 40, "wd_wrap_a");
      req[3] = 1'b0;
      wait_dones(1, 40, "wd_wrap_b");
      req[0] = 1'b0;
      @(negedge clk);

      // NACK on read of 0x7F
      m_nack_cfg = 1'b1;
      m_rd_cfg = 8'h99;
      setreq(1, 7'h7F, 1'b1, 8'h00);
      push(1, 7'h7F, 1, 8'h00, 0, 0, 2'b01);
      req[1] = 1'b1;
      wait_dones(1, 40, "wd_nack");
      req[1] = 1'b0;
      m_nack_cfg = 1'b0;
      @(negedge clk);

      // Master not ready blocks arbitration; req withdrawn after grant still completes
      m_block = 1'b1;
      setreq(1, 7'h33, 1'b0, 8'h44);
      push(1, 7'h33, 0, 8'h44, 0, 0, 2'b00);
      req[1] = 1'b1;
      blk_bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (grant !== 4'b0000 || busy !== 1'b0) blk_bad++;
      end
      chk("blocked_no_grant", blk_bad, 0);
      m_block = 1'b0;
      @(negedge clk);
      chk("grant_after_ready", grant, 4'b0010);
      req[1] = 1'b0;
      wait_dones(1, 40, "wd_withdrawn");
      @(negedge clk);

      // Reset during WAIT_DONE abandons the transaction
      m_lat = 200;
      setreq(2, 7'h45, 1'b1, 8'h00);
      req[2] = 1'b1;
      repeat (12) @(negedge clk);
      chk("in_wait_done", {busy, m_ready}, 2'b10);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_mid", {grant, done, m_enable, busy, err, rdata, m_addr, m_rw, m_wdata}, 0);
      req = 4'b0000;
      rst = 1'b1;
      m_lat = 6;
      @(negedge clk);

      // Pointer restarts at 0: requesters 1 and 2 granted in that order
      setreq(1, 7'h61, 1'b0, 8'h01);
      setreq(2, 7'h62, 1'b0, 8'h02);
      push(1, 7'h61, 0, 8'h01, 0, 0, 2'b00);
      push(2, 7'h62, 0, 8'h02, 0, 0, 2'b00);
      req = 4'b0110;
      wait_dones(1, 40, "wd_post_reset_a");
      req[1] = 1'b0;
      wait_dones(1, 40, "wd_post_reset_b");
      req[2] = 1'b0;
      @(negedge clk);

      // Timeout budget 16: ready on the last budget cycle wins, one cycle later loses
      t_run(0, 14, 8'h77, 2'b00, 8'h77);
      t_run(1, 15, 8'h66, 2'b10, 8'h00);
      t_run(0, -1, 8'h5A, 2'b10, 8'h00);

      repeat (5) @(negedge clk);
      chk("queues_empty", q.size() + tq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
